// File: rtl/imm_encoder_pkg.sv
// ============================================================================
// Module  : imm_encoder_pkg
// Purpose : Shared immediate-format codes, widths and request type for the
//           immediate encoder/decoder pair.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package imm_encoder_pkg;

    localparam int C_INST_W        = 32;
    localparam int C_ERR_CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_fmt_e;

    // Upper bits that must be a pure sign extension for each format.
    localparam logic [C_INST_W-1:0] C_MASK_31_11 = 32'hFFFF_F800;
    localparam logic [C_INST_W-1:0] C_MASK_31_12 = 32'hFFFF_F000;
    localparam logic [C_INST_W-1:0] C_MASK_31_20 = 32'hFFF0_0000;

    typedef struct packed {
        logic [2:0]          sel;
        logic [C_INST_W-1:0] imm;
        logic [C_INST_W-1:0] base;
    } imm_req_t;

    // True when the masked bits of v are all zeros or all ones.
    function automatic logic sext_ok(input logic [C_INST_W-1:0] v,
                                     input logic [C_INST_W-1:0] mask);
        logic [C_INST_W-1:0] m;
        m = v & mask;
        return (m == '0) || (m == mask);
    endfunction

endpackage : imm_encoder_pkg

`default_nettype wire

// File: rtl/imm_pack.sv
// ============================================================================
// Module  : imm_pack
// Purpose : Combinational scatter of an immediate into an instruction template
//           plus range/alignment/format checking.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]          i_sel,
    input  logic [C_INST_W-1:0] i_imm,
    input  logic [C_INST_W-1:0] i_base,
    output logic [C_INST_W-1:0] o_inst,
    output logic                o_err
);

    always_comb begin
        o_inst = i_base;
        o_err  = 1'b0;
        case (i_sel)
            IMM_I: begin
                o_inst[31:20] = i_imm[11:0];
                o_err         = !sext_ok(i_imm, C_MASK_31_11);
            end
            IMM_S: begin
                o_inst[31:25] = i_imm[11:5];
                o_inst[11:7]  = i_imm[4:0];
                o_err         = !sext_ok(i_imm, C_MASK_31_11);
            end
            IMM_B: begin
                o_inst[31]    = i_imm[12];
                o_inst[7]     = i_imm[11];
                o_inst[30:25] = i_imm[10:5];
                o_inst[11:8]  = i_imm[4:1];
                o_err         = !sext_ok(i_imm, C_MASK_31_12) || i_imm[0];
            end
            IMM_U: begin
                o_inst[31:12] = i_imm[19:0];
                o_err         = |i_imm[31:20];
            end
            IMM_J: begin
                o_inst[31]    = i_imm[20];
                o_inst[30:21] = i_imm[10:1];
                o_inst[20]    = i_imm[11];
                o_inst[19:12] = i_imm[19:12];
                o_err         = !sext_ok(i_imm, C_MASK_31_20) || i_imm[0];
            end
            // Unknown format: template passes through untouched, flagged.
            default: begin
                o_inst = i_base;
                o_err  = 1'b1;
            end
        endcase
    end

endmodule : imm_pack

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
// Module  : imm_encoder
// Purpose : Two-stage valid/ready pipeline that packs immediates into RISC-V
//           instruction templates and counts errored output words.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = C_ERR_CNT_W_DEF
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           im_sel,
    input  logic [C_INST_W-1:0]  imm,
    input  logic [C_INST_W-1:0]  base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [C_INST_W-1:0]  inst,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] C_CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic                 r_s1_vld;
    imm_req_t             r_s1_req;
    logic                 r_s2_vld;
    logic [C_INST_W-1:0]  r_s2_inst;
    logic                 r_s2_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_s2_rdy;
    logic [C_INST_W-1:0]  w_inst;
    logic                 w_err;
    logic                 w_out_hs;

    // S2 can take a word when empty or when its current word leaves this cycle.
    assign w_s2_rdy = !r_s2_vld || out_ready;
    assign in_ready = !r_s1_vld || w_s2_rdy;
    assign w_out_hs = r_s2_vld && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_req <= '0;
        end else if (in_ready) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_req.sel  <= im_sel;
                r_s1_req.imm  <= imm;
                r_s1_req.base <= base;
            end
        end
    end

    imm_pack u_imm_pack (
        .i_sel  (r_s1_req.sel),
        .i_imm  (r_s1_req.imm),
        .i_base (r_s1_req.base),
        .o_inst (w_inst),
        .o_err  (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_inst <= '0;
            r_s2_err  <= 1'b0;
        end else if (w_s2_rdy) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_inst <= w_inst;
                r_s2_err  <= w_err;
            end
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_out_hs && r_s2_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + C_CNT_ONE;
        end
    end

    assign out_valid = r_s2_vld;
    assign inst      = r_s2_inst;
    assign out_err   = r_s2_err;
    assign err_cnt   = r_err_cnt;

endmodule : imm_encoder

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
// Module  : tb_imm_encoder
// Purpose : Directed self-checking bench for imm_encoder with an in-order
//           expected-word queue.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  im_sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic        out_err;
    logic        err_clr;
    logic [7:0]  err_cnt;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    imm_encoder #(.ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .im_sel    (im_sel),
        .imm       (imm),
        .base      (base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Every visible output word is compared to the queue head, so stalled
    // words are re-checked each cycle and ordering is enforced.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                chk("inst", inst, exp_q[0][31:0]);
                chk("out_err", 32'(out_err), 32'(exp_q[0][32]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b,
                        input logic [31:0] ei, input logic ee);
        int t;
        t        = 0;
        in_valid = 1'b1;
        im_sel   = s;
        imm      = i;
        base     = b;
        exp_q.push_back({ee, ei});
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        im_sel    = 3'b000;
        imm       = '0;
        base      = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: out_valid two cycles after acceptance.
        send(3'b000, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
        @(negedge clk);
        chk("lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2", 32'(out_valid), 32'd1);
        drain();

        // Format vectors, back to back.
        send(3'b010, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
        send(3'b010, 32'h0000_0FFF, 32'h0000_0063, 32'h7E00_0FE3, 1'b1);
        send(3'b100, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0);
        send(3'b011, 32'h0001_2345, 32'h0000_0037, 32'h1234_5037, 1'b0);
        send(3'b001, 32'h0000_07FF, 32'h0000_0023, 32'h7E00_0FA3, 1'b0);
        send(3'b011, 32'h0010_0000, 32'h0000_0037, 32'h0000_0037, 1'b1);
        send(3'b100, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 1'b1);
        send(3'b000, 32'hFFFF_F7FF, 32'h0000_0013, 32'h7FF0_0013, 1'b1);
        send(3'b000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0);
        drain();

        // Error counter and illegal formats.
        clear_cnt();
        chk("cnt_cleared", 32'(err_cnt), 32'd0);
        send(3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
        drain();
        chk("cnt_one", 32'(err_cnt), 32'd1);
        send(3'b101, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1);
        send(3'b111, 32'h0000_0004, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
        drain();
        chk("cnt_three", 32'(err_cnt), 32'd3);

        // Clear coinciding with an errored handshake.
        out_ready = 1'b0;
        send(3'b110, 32'h0, 32'h0000_ABCD, 32'h0000_ABCD, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        err_clr   = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_priority", 32'(err_cnt), 32'd0);
        drain();
        chk("clr_hold", 32'(err_cnt), 32'd0);

        // Backpressure: four requests, consumer stalled.
        out_ready = 1'b0;
        fork
            begin
                send(3'b000, 32'h0000_0001, 32'h0000_0013, 32'h0010_0013, 1'b0);
                send(3'b000, 32'h0000_0002, 32'h0000_0013, 32'h0020_0013, 1'b0);
                @(negedge clk);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                send(3'b000, 32'h0000_0003, 32'h0000_0013, 32'h0030_0013, 1'b0);
                send(3'b000, 32'h0000_0004, 32'h0000_0013, 32'h0040_0013, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Saturation after 256 errored words.
        clear_cnt();
        for (int k = 0; k < 256; k++) begin
            send(3'b110, 32'(k), 32'(k), 32'(k), 1'b1);
        end
        drain();
        chk("cnt_saturate", 32'(err_cnt), 32'd255);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
        send(3'b000, 32'h0000_0005, 32'h0000_0013, 32'h0050_0013, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_inst", inst, 32'd0);
        chk("arst_out_err", 32'(out_err), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_flushed", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(3'b011, 32'h000A_BCDE, 32'h0000_0017, 32'hABCD_E017, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule : tb_imm_encoder

`default_nettype wire

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter ERR_CNT_W, default 8, width of saturating error counter.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-006 im_sel  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal.
REQ-007 imm  input  32  immediate value to encode.
REQ-008 base  input  32  instruction template (opcode/reg/funct fields); immediate bit positions overwritten.
REQ-009 out_valid  output  1  encoded word valid.
REQ-010 out_ready  input  1  consumer accepts when out_valid and out_ready are both high.
REQ-011 inst  output  32  encoded instruction word.
REQ-012 out_err  output  1  qualifies inst; range, alignment or format error.
REQ-013 err_clr  input  1  synchronous clear of err_cnt.
REQ-014 err_cnt  output  ERR_CNT_W  saturating count of errored words delivered.

Function
REQ-015 Two-stage pipeline: S1 registers request and computes range check; S2 holds assembled inst/out_err; latency exactly 2 cycles from acceptance to out_valid with out_ready held high.
REQ-016 Throughput one request per cycle with out_ready held high.
REQ-017 Each stage advances when its downstream stage is empty or advancing; in_ready = !S1_valid or S1 advancing (combinational, no dependency on in_valid).
REQ-018 inst, out_err and out_valid hold stable while out_valid=1 and out_ready=0; no loss, duplication or reordering.
REQ-019 I: inst[31:20]=imm[11:0]; error if imm[31:11] not all equal.
REQ-020 S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; error if imm[31:11] not all equal.
REQ-021 B: inst[31]=imm[12], inst[7]=imm[11], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1]; error if imm[31:12] not all equal or imm[0]=1.
REQ-022 U: inst[31:12]=imm[19:0] (right-justified upper field); error if imm[31:20] nonzero.
REQ-023 J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]; error if imm[31:20] not all equal or imm[0]=1.
REQ-024 All bits not listed for a format are copied from base unchanged.
REQ-025 On error the truncated encoding is still emitted, with out_err=1.
REQ-026 Illegal im_sel: inst=base unchanged, out_err=1.
REQ-027 err_cnt increments on each output handshake with out_err=1, saturating at all-ones.
REQ-028 err_clr has priority over a same-cycle increment; err_cnt=0 next cycle.

Reset
REQ-029 Asserting rst_n low immediately clears S1/S2 valid, out_valid=0, out_err=0, inst=0, err_cnt=0; in-flight requests are discarded.
REQ-030 in_ready=1 from the first cycle after rst_n deasserts.

Structure
REQ-031 Format codes (I/S/B/U/J), instruction width 32 and ERR_CNT_W default are defined in a shared package, common with the immediate decoder.
REQ-032 Encoding and range check are implemented in one combinational sub-module, imm_pack, instantiated between S1 and S2.

Verification
REQ-033 I, imm=0xFFFFF800, base=0x00000013 -> inst=0x80000013, out_err=0, out_valid 2 cycles after acceptance.
REQ-034 B, imm=0x00000FFE, base=0x00000063 -> inst=0x7E000FE3, out_err=0; same with imm=0x00000FFF -> out_err=1.
REQ-035 J, imm=0xFFFFFFFE, base=0x0000006F -> inst=0xFFFFF06F; U, imm=0x00012345, base=0x00000037 -> inst=0x12345037.
REQ-036 I, imm=0x00000800, base=0x00000013 -> inst=0x80000013, out_err=1, err_cnt 0->1; im_sel=101 -> inst=base, out_err=1.
REQ-037 Backpressure: 4 back-to-back requests, out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepted;
  - all 4 delivered in order, outputs stable while stalled.
REQ-038 rst_n asserted with both stages full -> out_valid=0 at once, err_cnt=0; 256 errored words with ERR_CNT_W=8 -> err_cnt=255.
